// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: round-robin share of one SPI master among N_REQ
// requesters; latches {4'b1000, addr, data} frames, acks the served one.
//
// Ports:
//   sys_clk, sys_rst         clock, synchronous active-high reset
//   req/req_addr/req_data    per-requester level request + payload
//   ack, err                 one-cycle completion / timeout pulses
//   grant_id, arb_busy       current grant, non-idle status
//   spi_start, spi_frame     start pulse + frame held until spi_done
//   spi_busy, spi_done       handshake from the SPI master
//
// Optional watchdog: define SPI_ARB_TIMEOUT_EN (limit TMO_CYC cycles).

module spi_req_arbiter #(
  parameter int N_REQ   = 4,
  parameter int GAP_CYC = 10,
  parameter int TMO_CYC = 4096
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [4*N_REQ-1:0]  req_addr,
  input  logic [16*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]    ack,
  output logic [N_REQ-1:0]    err,
  output logic [2:0]          grant_id,
  output logic                arb_busy,
  output logic                spi_start,
  output logic [23:0]         spi_frame,
  input  logic                spi_busy,
  input  logic                spi_done
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    GAP
  } state_t;

  localparam int GW =
    (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);
  localparam logic [2:0] LAST_ID = 3'(N_REQ - 1);
  localparam state_t POST =
    (GAP_CYC == 0) ? IDLE : GAP;

  state_t          state, state_n;
  logic [2:0]      rr_ptr, rr_n;
  logic [2:0]      grant_n;
  logic [23:0]     frame_n;
  logic            start_n;
  logic [N_REQ-1:0] ack_n;
  logic [GW-1:0]   gap_cnt, gap_n;
  logic [2:0]      pick;
  logic            hit;
  logic [2:0]      next_id;
  logic            done_ok;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW =
    (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TMO_CYC - 1);

  logic [TW-1:0]    wdog, wdog_n;
  logic [N_REQ-1:0] err_q, err_n;

  assign err = err_q;
`else
  assign err = '0;
`endif

  assign arb_busy = (state != IDLE);

  // spi_start is high during the first WAIT_DONE cycle;
  // a done seen alongside it belongs to no frame of ours.
  assign done_ok = spi_done && !spi_start;

  assign next_id = (grant_id == LAST_ID) ?
                   3'd0 : grant_id + 3'd1;

  // Descending scan: the lowest offset from rr_ptr wins.
  always_comb begin
    pick = '0;
    hit  = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % N_REQ]) begin
        pick = 3'((int'(rr_ptr) + k) % N_REQ);
        hit  = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    rr_n    = rr_ptr;
    grant_n = grant_id;
    frame_n = spi_frame;
    start_n = 1'b0;
    ack_n   = '0;
    gap_n   = gap_cnt;
`ifdef SPI_ARB_TIMEOUT_EN
    wdog_n  = wdog;
    err_n   = '0;
`endif
    unique case (state)
      IDLE: begin
        if (hit) begin
          grant_n = pick;
          frame_n = {4'b1000,
                     req_addr[4*int'(pick) +: 4],
                     req_data[16*int'(pick) +: 16]};
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (!spi_busy) begin
          start_n = 1'b1;
          state_n = WAIT_DONE;
`ifdef SPI_ARB_TIMEOUT_EN
          wdog_n  = '0;
`endif
        end
      end
      WAIT_DONE: begin
        if (done_ok) begin
          ack_n   = ONE << grant_id;
          rr_n    = next_id;
          gap_n   = '0;
          state_n = POST;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (wdog == TMO_LAST) begin
          err_n   = ONE << grant_id;
          rr_n    = next_id;
          gap_n   = '0;
          state_n = POST;
        end else begin
          wdog_n  = wdog + 1'b1;
        end
`endif
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_n = IDLE;
        end else begin
          gap_n = gap_cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      spi_frame <= '0;
      spi_start <= 1'b0;
      ack       <= '0;
      gap_cnt   <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      wdog      <= '0;
      err_q     <= '0;
`endif
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_n;
      grant_id  <= grant_n;
      spi_frame <= frame_n;
      spi_start <= start_n;
      ack       <= ack_n;
      gap_cnt   <= gap_n;
`ifdef SPI_ARB_TIMEOUT_EN
      wdog      <= wdog_n;
      err_q     <= err_n;
`endif
    end
  end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb_spi_req_arbiter: vector table, hand sequences and a
// randomized run against a transaction-level arbiter model.

module tb_spi_req_arbiter;

  localparam int N   = 4;
  localparam int GAP = 10;
  localparam int TMO = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [4*N-1:0] req_addr = '0;
  logic [16*N-1:0] req_data = '0;
  logic [N-1:0]   ack, err;
  logic [2:0]     grant_id;
  logic           arb_busy, spi_start;
  logic [23:0]    spi_frame;
  logic           spi_busy, spi_done;
  logic           m_busy = 1'b0, m_done = 1'b0;
  logic           h_busy = 1'b0, h_done = 1'b0;

  assign spi_busy = m_busy | h_busy;
  assign spi_done = m_done | h_done;

  always #10 clk = ~clk;

  spi_req_arbiter #(
    .N_REQ(N), .GAP_CYC(GAP), .TMO_CYC(TMO)
  ) dut (
    .sys_clk(clk), .sys_rst(rst),
    .req(req), .req_addr(req_addr),
    .req_data(req_data), .ack(ack), .err(err),
    .grant_id(grant_id), .arb_busy(arb_busy),
    .spi_start(spi_start), .spi_frame(spi_frame),
    .spi_busy(spi_busy), .spi_done(spi_done)
  );

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  bit auto_en = 1'b1;
  int done_lat = 3;

  typedef struct {
    logic [3:0]  rq;
    logic [2:0]  gid;
    logic [23:0] frame;
  } vec_t;

  vec_t tbl[7];
  logic [23:0] fr[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic fail_to(input string nm, input int lim);
    checks++;
    errors++;
    $display("FAIL %s: no event within %0d cycles",
             nm, lim);
  endtask

  task automatic wait_start(input string nm,
                            output int n);
    n = 0;
    while (n < 500) begin
      tick();
      n++;
      if (spi_start) return;
    end
    fail_to(nm, 500);
  endtask

  task automatic wait_ack(input string nm,
                          output int n);
    n = 0;
    while (n < 500) begin
      tick();
      n++;
      if (ack != 0) return;
    end
    fail_to(nm, 500);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (arb_busy) begin
      tick();
      n++;
      if (n > 200) begin
        fail_to(nm, 200);
        return;
      end
    end
  endtask

  task automatic set_rd(input int i,
                        input logic [3:0] a,
                        input logic [15:0] d);
    req_addr[4*i +: 4]   = a;
    req_data[16*i +: 16] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // SPI master: busy while shifting, done after done_lat cycles.
  initial begin
    forever begin
      tick();
      if (auto_en && spi_start) begin
        m_busy = 1'b1;
        repeat (done_lat) tick();
        m_done = 1'b1;
        m_busy = 1'b0;
        tick();
        m_done = 1'b0;
      end
    end
  end

  always @(negedge clk)
    if (err != 0) err_seen++;

  initial begin
    int n, n2, g, cnt;
    int mrr, ntx, cyc, want, j;
    bit pend[N];
    bit any;
    logic [3:0]  ra[N];
    logic [15:0] rd[N];
    int q[$];

    fr[0] = 24'h84E6B7;
    fr[1] = 24'h891234;
    fr[2] = 24'h8ABEEF;
    fr[3] = 24'h830F0F;
    tbl[0] = '{4'b1111, 3'd1, 24'h891234};
    tbl[1] = '{4'b0001, 3'd0, 24'h84E6B7};
    tbl[2] = '{4'b1001, 3'd3, 24'h830F0F};
    tbl[3] = '{4'b0110, 3'd1, 24'h891234};
    tbl[4] = '{4'b0011, 3'd0, 24'h84E6B7};
    tbl[5] = '{4'b1100, 3'd2, 24'h8ABEEF};
    tbl[6] = '{4'b0111, 3'd0, 24'h84E6B7};

    set_rd(0, 4'h4, 16'hE6B7);
    set_rd(1, 4'h9, 16'h1234);
    set_rd(2, 4'hA, 16'hBEEF);
    set_rd(3, 4'h3, 16'h0F0F);

    // reset state
    tick();
    do_reset();
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_start", spi_start, 0);
    chk("rst_frame", spi_frame, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_busy", arb_busy, 0);

    // single request, long frame, gap and regrant spacing
    done_lat = 240;
    req = 4'b0001;
    wait_start("single_start", n);
    chk("single_lat", n, 2);
    chk("single_gid", grant_id, 0);
    chk("single_frame", spi_frame, 24'h84E6B7);
    wait_ack("single_ack", n);
    chk("single_ack_lat", n, 241);
    chk("single_ack", ack, 4'b0001);
    g = 0;
    while (arb_busy && g < 100) begin
      g++;
      tick();
      if (g == 1) chk("ack_width", ack, 0);
    end
    chk("gap_len", g, GAP);
    done_lat = 3;
    wait_start("regrant_start", n2);
    chk("regrant_gap", g + n2, GAP + 2);
    chk("regrant_gid", grant_id, 0);
    wait_ack("regrant_ack", n);
    chk("regrant_ack", ack, 4'b0001);
    req = '0;
    wait_idle("single_idle");

    // table of request patterns (rr_ptr starts at 1)
    for (int i = 0; i < 7; i++) begin
      req = tbl[i].rq;
      wait_start("tbl_start", n);
      chk($sformatf("tbl%0d_gid", i),
          grant_id, tbl[i].gid);
      chk($sformatf("tbl%0d_frame", i),
          spi_frame, tbl[i].frame);
      wait_ack("tbl_ack", n);
      chk($sformatf("tbl%0d_ack", i),
          ack, 1 << tbl[i].gid);
      req = '0;
      wait_idle("tbl_idle");
    end

    // busy hold in ISSUE
    h_busy = 1'b1;
    req = 4'b0100;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (spi_start) cnt++;
    end
    chk("busy_nostart", cnt, 0);
    h_busy = 1'b0;
    tick();
    chk("busy_start", spi_start, 1);
    chk("busy_gid", grant_id, 2);
    cnt = 0;
    n = 0;
    while (ack == 0 && n < 200) begin
      tick();
      n++;
      if (spi_start) cnt++;
    end
    chk("busy_once", cnt, 0);
    chk("busy_ack", ack, 4'b0100);
    req = '0;
    wait_idle("busy_idle");

    // payload and request change after grant
    done_lat = 30;
    req = 4'b0100;
    wait_start("mid_start", n);
    chk("mid_gid", grant_id, 2);
    repeat (3) tick();
    req[2] = 1'b0;
    set_rd(2, 4'h1, 16'h5555);
    tick();
    chk("mid_frame", spi_frame, 24'h8ABEEF);
    wait_ack("mid_ack", n);
    chk("mid_ack", ack, 4'b0100);
    set_rd(2, 4'hA, 16'hBEEF);
    cnt = 0;
    for (int i = 0; i < GAP + 6; i++) begin
      tick();
      if (spi_start) cnt++;
    end
    chk("mid_noregrant", cnt, 0);
    wait_idle("mid_idle");

    // spi_done in IDLE and in the spi_start cycle
    done_lat = 3;
    h_done = 1'b1;
    tick();
    h_done = 1'b0;
    chk("idle_done_busy", arb_busy, 0);
    chk("idle_done_ack", ack, 0);
    auto_en = 1'b0;
    req = 4'b0100;
    wait_start("early_start", n);
    h_done = 1'b1;
    tick();
    h_done = 1'b0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ack != 0) cnt++;
    end
    chk("early_noack", cnt, 0);
    chk("early_busy", arb_busy, 1);
    h_done = 1'b1;
    tick();
    h_done = 1'b0;
    chk("early_ack", ack, 4'b0100);
    req = '0;
    wait_idle("early_idle");

    // reset in WAIT_DONE
    req = 4'b0001;
    wait_start("rstmid_start", n);
    chk("rstmid_gid0", grant_id, 0);
    repeat (3) tick();
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
    chk("rstmid_busy", arb_busy, 0);
    chk("rstmid_frame", spi_frame, 0);
    chk("rstmid_gid", grant_id, 0);
    chk("rstmid_ack", ack, 0);
    chk("rstmid_start", spi_start, 0);
    auto_en = 1'b1;
    req = 4'b1100;
    wait_start("rstmid_start2", n);
    chk("rstmid_regrant", grant_id, 2);
    chk("rstmid_frame2", spi_frame, 24'h8ABEEF);
    wait_ack("rstmid_ack2", n);
    chk("rstmid_ack2", ack, 4'b0100);
    req = '0;
    wait_idle("rstmid_idle");

    // all requesters held high
    do_reset();
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_start("rr_start", n);
      chk($sformatf("rr%0d_gid", t), grant_id, t % 4);
      chk($sformatf("rr%0d_frame", t),
          spi_frame, fr[t % 4]);
      wait_ack("rr_ack", n);
      chk($sformatf("rr%0d_ack", t), ack, 1 << (t % 4));
    end
    req = '0;
    wait_idle("rr_idle");

    // randomized traffic vs transaction-level model
    do_reset();
    mrr = 0;
    ntx = 0;
    cyc = 0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'($urandom_range(0, 1));
      ra[i] = 4'($urandom);
      rd[i] = 16'($urandom);
      if (pend[i]) any = 1'b1;
    end
    if (!any) pend[$urandom_range(0, N-1)] = 1'b1;
    for (int i = 0; i < N; i++) begin
      req[i] = pend[i];
      set_rd(i, ra[i], rd[i]);
    end
    while (ntx < 40 && cyc < 20000) begin
      tick();
      cyc++;
      h_busy = ($urandom_range(0, 3) == 0);
      if (spi_start) begin
        want = -1;
        for (int k = 0; k < N; k++) begin
          j = (mrr + k) % N;
          if (pend[j]) begin
            want = j;
            break;
          end
        end
        if (want < 0) begin
          fail_to("rnd_grant_nopend", 0);
        end else begin
          chk("rnd_gid", grant_id, want);
          chk("rnd_frame", spi_frame,
              {8'h0, 4'h8, ra[want], rd[want]});
        end
        q.push_back(want);
      end
      if (ack != 0) begin
        if (q.size() == 0) begin
          fail_to("rnd_ack_unexpected", 0);
        end else begin
          want = q.pop_front();
          chk("rnd_ack", ack, 1 << want);
          if (want >= 0) begin
            mrr = (want + 1) % N;
            pend[want] = 1'b0;
          end
          ntx++;
          any = 1'b0;
          for (int i = 0; i < N; i++) begin
            if (!pend[i] &&
                $urandom_range(0, 2) == 0) begin
              pend[i] = 1'b1;
              ra[i] = 4'($urandom);
              rd[i] = 16'($urandom);
            end
            if (pend[i]) any = 1'b1;
          end
          if (!any) begin
            j = $urandom_range(0, N-1);
            pend[j] = 1'b1;
            rd[j] = 16'($urandom);
          end
          for (int i = 0; i < N; i++) begin
            req[i] = pend[i];
            set_rd(i, ra[i], rd[i]);
          end
          done_lat = $urandom_range(1, 20);
        end
      end
    end
    chk("rnd_tx_count", ntx, 40);
    h_busy = 1'b0;
    req = '0;
    wait_idle("rnd_idle");

`ifdef SPI_ARB_TIMEOUT_EN
    auto_en = 1'b0;
    req = 4'b0001;
    wait_start("tmo_start", n);
    n = 0;
    while (n < 200) begin
      tick();
      n++;
      if (err != 0) break;
    end
    chk("tmo_cycles", n, TMO);
    chk("tmo_err", err, 4'b0001);
    chk("tmo_noack", ack, 0);
    req = '0;
    tick();
    chk("tmo_err_width", err, 0);
    repeat (4) tick();
    h_done = 1'b1;
    tick();
    h_done = 1'b0;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (ack != 0) cnt++;
    end
    chk("tmo_late_done", cnt, 0);
    wait_idle("tmo_idle");
    auto_en = 1'b1;
`else
    chk("err_const0", err_seen, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_req_arbiter.md
Name: spi_req_arbiter

Overview:
- Shares one SPI master between N independent requesters (config FSMs, host bridge, calibration logic).
- Arbitrates round-robin and latches the winner's 4-bit address and 16-bit data.
- Builds the 24-bit write frame {4'b1000, addr, data} and drives the master's start/busy/done handshake.
- Enforces a minimum CS-high gap between frames and returns a one-cycle ack to the served requester.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- GAP_CYC, 10, idle sys_clk cycles after each spi_done before the next grant (0 allowed).
- TMO_CYC, 4096, watchdog limit in sys_clk cycles from spi_start to spi_done (used only with the optional feature).

Ports:
- sys_clk  in  1  system clock (50 MHz); all logic on the rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester level request, held high until its ack.
- req_addr  in  4*N_REQ  requester i address at [4i+3:4i].
- req_data  in  16*N_REQ  requester i data at [16i+15:16i].
- ack  out  N_REQ  one-cycle completion pulse to the served requester.
- err  out  N_REQ  one-cycle timeout pulse (optional feature only, else tied 0).
- grant_id  out  3  index of the current or last granted requester.
- arb_busy  out  1  high whenever the state is not IDLE.
- spi_start  out  1  one-cycle start pulse to the SPI master.
- spi_frame  out  24  frame to the SPI master, MSB first; stable from spi_start until spi_done.
- spi_busy  in  1  SPI master busy (CS low / shifting).
- spi_done  in  1  one-cycle end-of-frame pulse from the SPI master.

Behaviour:
- Reset (synchronous, sys_rst=1 at a clock edge):
  - state=IDLE, rr_ptr=0, ack=0, err=0, spi_start=0, spi_frame=0, grant_id=0, arb_busy=0, gap/watchdog counters=0.
  - Reset mid-transaction abandons the frame with no ack; handling the SPI master is the integrator's responsibility.
- States: IDLE, ISSUE, WAIT_DONE, GAP.
- IDLE, when |req:
  - Pick the first set req scanning from rr_ptr upward, wrapping modulo N_REQ.
  - Register grant_id, latch spi_frame={4'b1000, req_addr[g], req_data[g]}, go to ISSUE.
  - Latency from req rising to spi_start is 2 cycles minimum.
- ISSUE:
  - If spi_busy=0, assert spi_start for exactly one cycle and go to WAIT_DONE.
  - If spi_busy=1, hold in ISSUE without a pulse.
- WAIT_DONE:
  - On spi_done: pulse ack[grant_id] next cycle, set rr_ptr=(grant_id+1) mod N_REQ, go to GAP; if GAP_CYC=0, go straight to IDLE.
- GAP: count GAP_CYC cycles, then go to IDLE. No grant is issued during GAP.
- Boundary conditions:
  - spi_done in IDLE, ISSUE or GAP is ignored.
  - spi_done in the same cycle as the spi_start pulse is ignored; done is only accepted in WAIT_DONE.
  - A requester that drops req after its grant still gets its frame sent and its ack pulsed.
  - Frame and grant are frozen once latched; later req_addr/req_data changes are ignored.
  - The acked requester sampling req still high in the ack cycle does not cause a duplicate grant: earliest re-arbitration is after GAP, and rr_ptr has already advanced.
  - All requests high continuously gives a strict order 0,1,2,3,0,...
  - One requester only: consecutive grants are separated by ≥ GAP_CYC+2 cycles.

Optional Feature:
- Macro SPI_ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counts in WAIT_DONE.
  - On reaching TMO_CYC without spi_done: pulse err[grant_id] (ack stays 0), advance rr_ptr, go to GAP.
  - A late spi_done arriving afterwards is ignored.
- Undefined:
  - No watchdog counter; WAIT_DONE waits indefinitely; err is constant 0.

Test Plan:
- Single request: reset, req=4'b0001, addr0=4'h4, data0=16'hE6B7 -> spi_frame=24'h84E6B7, spi_start 2 cycles after req; spi_done after 240 cycles -> ack=4'b0001 one cycle later, then GAP_CYC=10 idle cycles.
- Round robin: req=4'b1111 held for 5 transactions -> grant_id sequence 0,1,2,3,0; each frame carries its requester's addr/data; exactly one ack per transaction.
- Busy hold: spi_busy=1 for 20 cycles when ISSUE is entered -> no spi_start until the cycle after spi_busy falls; then exactly one pulse.
- Mid-transaction changes: change req_data2 and drop req[2] during WAIT_DONE -> spi_frame unchanged, ack[2] still pulses, requester 2 not regranted.
- Reset mid-operation: assert sys_rst for 1 cycle in WAIT_DONE -> all outputs 0, state IDLE; with req=4'b0100 held, next grant is 2 (rr_ptr=0 scan).
- Timeout (SPI_ARB_TIMEOUT_EN, TMO_CYC=64): withhold spi_done -> err[grant_id] pulses at cycle 64 after spi_start, ack stays 0; a spi_done injected 5 cycles later is ignored.
